// File: rtl/encoder_8x3_scan.sv
// encoder_8x3_scan: sequential 8-to-3 scanning encoder.
// Accepts an 8-bit request vector on a valid/ready handshake. It then emits
// the index of every set bit, lowest first, one index per output handshake.
// The final beat is flagged, and an all-zero vector gives one out_none beat.
// All outputs decode registered state only.
module encoder_8x3_scan (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_last,
  output logic       out_none,
  output logic [3:0] out_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] pend_q,  pend_d;
  logic [3:0] cnt_q,   cnt_d;

  logic [3:0] in_popcount;
  logic [2:0] low_idx;
  logic       at_most_one;
  logic       pend_zero;
  logic       emitting;

  // Count the set bits of the incoming vector. The result is loaded into cnt at acceptance.
  always_comb begin
    in_popcount = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      in_popcount = in_popcount + {3'b000, in_data[i]};
    end
  end

  // Find the lowest pending index, and flag when at most one bit is still pending.
  always_comb begin
    logic found;
    found   = 1'b0;
    low_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && pend_q[i]) begin
        low_idx = 3'(i);
        found   = 1'b1;
      end
    end
    pend_zero   = (pend_q == 8'h00);
    at_most_one = ((pend_q & (pend_q - 8'd1)) == 8'h00);
  end

  // Drive the outputs from state. They are forced to zero outside EMIT, so reset and IDLE look identical.
  always_comb begin
    emitting  = (state_q == ST_EMIT);
    in_ready  = (state_q == ST_IDLE);
    out_valid = emitting;
    out_code  = emitting ? low_idx : 3'd0;
    out_last  = emitting & at_most_one;
    out_none  = emitting & pend_zero;
    out_count = emitting ? cnt_q : 4'd0;
  end

  // Next-state logic: load in IDLE, then retire one pending bit per output handshake in EMIT.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pend_d  = in_data;
          cnt_d   = in_popcount;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (at_most_one) begin
            pend_d  = '0;
            state_d = ST_IDLE;
          end else begin
            // pend & (pend-1) clears exactly the lowest set bit, which is the bit at low_idx.
            pend_d = pend_q & (pend_q - 8'd1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers: asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
